// File: rtl/mesm6_alu_ctl_pkg.sv
// Controller state encoding, default watchdog limit and typed op-code constants.
`include "mesm6_defines.sv"

package mesm6_alu_ctl_pkg;

  localparam int ALU_OP_W = `ALU_OP_WIDTH;

  localparam logic [ALU_OP_W-1:0] OP_NOP    = `ALU_NOP;
  localparam logic [ALU_OP_W-1:0] OP_AND    = `ALU_AND;
  localparam logic [ALU_OP_W-1:0] OP_OR     = `ALU_OR;
  localparam logic [ALU_OP_W-1:0] OP_XOR    = `ALU_XOR;
  localparam logic [ALU_OP_W-1:0] OP_SHIFT  = `ALU_SHIFT;
  localparam logic [ALU_OP_W-1:0] OP_PACK   = `ALU_PACK;
  localparam logic [ALU_OP_W-1:0] OP_UNPACK = `ALU_UNPACK;
  localparam logic [ALU_OP_W-1:0] OP_ARX    = `ALU_ADD_CARRY_AROUND;
  localparam logic [ALU_OP_W-1:0] OP_ACX    = `ALU_ACX;
  localparam logic [ALU_OP_W-1:0] OP_ANX    = `ALU_ANX;
  localparam logic [ALU_OP_W-1:0] OP_FADD   = `ALU_FADD;

  localparam int ALU_CTL_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } alu_ctl_state_t;

endpackage

// File: rtl/mesm6_alu_wdog.sv
// RUN-cycle watchdog: down-counter loaded on RUN entry, expires at terminal count.
module mesm6_alu_wdog
  import mesm6_alu_ctl_pkg::*;
#(
  parameter int TIMEOUT = ALU_CTL_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  // Loading TIMEOUT-1 makes the TIMEOUT-th RUN cycle the one that sees zero.
  localparam logic [3:0] TC_LOAD = 4'(TIMEOUT - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= TC_LOAD;
    end else if (run && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expired = run && (cnt == 4'd0);

endmodule

// File: rtl/mesm6_defines.sv
// Shared MESM-6 ALU op codes and op-code width.
`ifndef MESM6_DEFINES_SV
`define MESM6_DEFINES_SV

`define ALU_OP_WIDTH         4
`define ALU_NOP              4'd0
`define ALU_AND              4'd1
`define ALU_OR               4'd2
`define ALU_XOR              4'd3
`define ALU_SHIFT            4'd4
`define ALU_PACK             4'd5
`define ALU_UNPACK           4'd6
`define ALU_ADD_CARRY_AROUND 4'd7
`define ALU_ACX              4'd8
`define ALU_ANX              4'd9
`define ALU_FADD             4'd10

`endif

// File: rtl/mesm6_alu_ctl.sv
// ALU sequencer: one command at a time into mesm6_alu, response held until taken.
// Optional RUN watchdog enabled by defining MESM6_ALU_TIMEOUT_EN.
//
// state | meaning
// INIT  | one NOP cycle after reset to clear the ALU's unreset done
// IDLE  | ready for a command; NOP commands may pulse alu_wy
// RUN   | latched op driven to the ALU, waiting for done (or timeout)
// RESP  | response held, ALU parked on NOP until rsp_ready
`include "mesm6_defines.sv"

module mesm6_alu_ctl
  import mesm6_alu_ctl_pkg::*;
#(
  parameter int TIMEOUT = ALU_CTL_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [`ALU_OP_WIDTH-1:0] cmd_op,
  input  logic                     cmd_wy,
  input  logic [47:0]              cmd_a,
  input  logic [47:0]              cmd_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [47:0]              rsp_result,
  output logic [47:0]              rsp_y,
  output logic                     rsp_err,
  output logic [`ALU_OP_WIDTH-1:0] alu_op,
  output logic                     alu_wy,
  output logic [47:0]              alu_a,
  output logic [47:0]              alu_b,
  input  logic [47:0]              alu_result,
  input  logic [47:0]              alu_y,
  input  logic                     alu_done
);

  alu_ctl_state_t state, state_nx;

  logic [`ALU_OP_WIDTH-1:0] op_q;
  logic [47:0]              a_q, b_q;
  logic                     start;
  logic                     expired;

  assign start = (state == ST_IDLE) && cmd_valid && (cmd_op != OP_NOP);

`ifdef MESM6_ALU_TIMEOUT_EN
  logic err_q;

  mesm6_alu_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start),
    .run     (state == ST_RUN),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (state == ST_RUN) begin
      if (alu_done) err_q <= 1'b0;
      else if (expired) err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  logic [3:0] unused_timeout;

  assign unused_timeout = 4'(TIMEOUT - 1);
  assign expired        = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_op    = OP_NOP;
    alu_wy    = 1'b0;
    alu_a     = 48'd0;
    alu_b     = 48'd0;
    case (state)
      ST_INIT: state_nx = ST_IDLE;
      ST_IDLE: begin
        cmd_ready = 1'b1;
        alu_a     = cmd_a;
        // Y := A rides on the NOP cycle itself, so NOP/wy commands need no RUN.
        alu_wy    = cmd_valid && (cmd_op == OP_NOP) && cmd_wy;
        if (start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        alu_op = op_q;
        alu_a  = a_q;
        alu_b  = b_q;
        if (alu_done || expired) state_nx = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_NOP;
      a_q        <= 48'd0;
      b_q        <= 48'd0;
      rsp_result <= 48'd0;
      rsp_y      <= 48'd0;
    end else begin
      if (start) begin
        op_q <= cmd_op;
        a_q  <= cmd_a;
        b_q  <= cmd_b;
      end
      if (state == ST_RUN) begin
        if (alu_done) begin
          rsp_result <= alu_result;
          rsp_y      <= alu_y;
        end else if (expired) begin
          rsp_result <= 48'd0;
          rsp_y      <= 48'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mesm6_alu_ctl.sv
// Scoreboard bench for mesm6_alu_ctl with a behavioural ALU stand-in.
module tb_mesm6_alu_ctl;
  import mesm6_alu_ctl_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic        cmd_wy = 1'b0;
  logic [47:0] cmd_a = 48'd0, cmd_b = 48'd0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [47:0] rsp_result, rsp_y;
  logic        rsp_err;
  logic [3:0]  alu_op;
  logic        alu_wy;
  logic [47:0] alu_a, alu_b;
  logic [47:0] alu_result = 48'd0, alu_y = 48'd0;
  logic        alu_done = 1'b1;

  always #5 clk = ~clk;

  mesm6_alu_ctl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wy(cmd_wy),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_y(rsp_y), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_wy(alu_wy), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_y(alu_y), .alu_done(alu_done)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU latency in cycles; 0 means the op never finishes.
  function automatic int lat(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_SHIFT, OP_PACK, OP_UNPACK: return 1;
      OP_ARX, OP_ACX, OP_ANX: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [47:0] ref_f(input logic [3:0] op, input logic [47:0] a, b);
    logic [48:0] s;
    int n;
    case (op)
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_SHIFT: begin
        n = 64 - int'(b[46:41]);
        if (b[47]) return a >> n;
        return a << n;
      end
      OP_ARX: begin
        s = {1'b0, a} + {1'b0, b};
        return s[47:0] + {47'd0, s[48]};
      end
      default: return 48'd0;
    endcase
  endfunction

  // ALU stand-in: NOP clears done/count and performs Y := A; others finish after lat() cycles.
  int st_cnt = 0;
  always @(posedge clk) begin
    if (alu_op == OP_NOP) begin
      alu_done <= 1'b0;
      st_cnt   <= 0;
      if (alu_wy) alu_y <= alu_a;
    end else begin
      st_cnt <= st_cnt + 1;
      if (st_cnt + 1 == lat(alu_op)) begin
        alu_done   <= 1'b1;
        alu_result <= ref_f(alu_op, alu_a, alu_b);
      end
    end
  end

  typedef struct {
    logic [47:0] res;
    logic [47:0] y;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  logic [47:0] y_ref = 48'd0;
  int          last_acc = 0;
  bit          hold_rdy = 1'b0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic wy, input logic [47:0] a, input logic [47:0] b);
    bit   ok;
    exp_t e;
    cmd_op = op; cmd_wy = wy; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    #1;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("cmd_accept", {47'd0, ok}, 48'd1);
    if (ok) begin
      last_acc = cyc;
      chk("alu_wy", {47'd0, alu_wy}, {47'd0, (op == OP_NOP) && wy});
      if (op == OP_NOP) begin
        if (wy) y_ref = a;
      end else if (lat(op) == 0) begin
        e.res = 48'd0; e.y = 48'd0; e.err = 1'b1; e.due = cyc + TO + 1;
        sb.push_back(e);
      end else begin
        e.res = ref_f(op, a, b); e.y = y_ref; e.err = 1'b0; e.due = cyc + lat(op) + 2;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500; k++) begin
      if (sb.size() == 0 && cmd_ready) break;
      @(negedge clk); #1;
    end
    chk("drain", 48'(sb.size()), 48'd0);
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency on response entry, contents on consumption.
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      chk("rdy_vld_excl", {47'd0, cmd_ready & rsp_valid}, 48'd0);
      if (rsp_valid && !prev_v) begin
        if (sb.size() == 0) chk("unexpected_rsp", 48'd1, 48'd0);
        else chk("rsp_latency", 48'(cyc), 48'(sb[0].due));
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        e_mon = sb.pop_front();
        chk("rsp_result", rsp_result, e_mon.res);
        chk("rsp_y", rsp_y, e_mon.y);
        chk("rsp_err", {47'd0, rsp_err}, {47'd0, e_mon.err});
      end
      prev_v = rsp_valid;
    end
  end

  initial begin
    int acc0;
    logic [3:0] op;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_alu_op", {44'd0, alu_op}, {44'd0, OP_NOP});
    chk("rst_cmd_ready", {47'd0, cmd_ready}, 48'd0);
    chk("rst_rsp_valid", {47'd0, rsp_valid}, 48'd0);
    chk("rst_rsp_err", {47'd0, rsp_err}, 48'd0);
    chk("rst_rsp_result", rsp_result, 48'd0);
    chk("rst_rsp_y", rsp_y, 48'd0);
    chk("rst_alu_a", alu_a, 48'd0);
    chk("rst_alu_b", alu_b, 48'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("init_alu_op", {44'd0, alu_op}, {44'd0, OP_NOP});
    chk("init_cmd_ready", {47'd0, cmd_ready}, 48'd0);
    @(negedge clk); #1;
    chk("idle_cmd_ready", {47'd0, cmd_ready}, 48'd1);

    issue(OP_AND, 1'b0, 48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_FF00);
    issue(OP_ARX, 1'b0, 48'hFFFF_FFFF_FFFF, 48'd1);
    drain();

    hold_rdy = 1'b1;
    rsp_ready = 1'b0;
    issue(OP_SHIFT, 1'b0, 48'd1, {1'b0, 6'd63, 41'd0});
    for (int k = 0; k < 50; k++) begin
      if (rsp_valid) break;
      @(negedge clk); #1;
    end
    chk("shift_rsp_seen", {47'd0, rsp_valid}, 48'd1);
    repeat (5) begin
      @(negedge clk); #1;
      chk("hold_rsp_valid", {47'd0, rsp_valid}, 48'd1);
      chk("hold_rsp_result", rsp_result, 48'd2);
      chk("hold_cmd_ready", {47'd0, cmd_ready}, 48'd0);
      chk("hold_alu_op", {44'd0, alu_op}, {44'd0, OP_NOP});
    end
    hold_rdy = 1'b0;
    drain();

    issue(OP_NOP, 1'b1, 48'h123, 48'd0);
    acc0 = last_acc;
    issue(OP_AND, 1'b0, 48'hFFFF_0000_FFFF, 48'h0F0F_0F0F_0F0F);
    chk("nop_next_accept", 48'(last_acc), 48'(acc0 + 1));
    drain();

    for (int i = 0; i < 4; i++) begin
      acc0 = last_acc;
      issue(OP_NOP, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 48'd0);
      if (i > 0) chk("nop_b2b", 48'(last_acc), 48'(acc0 + 1));
    end

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: op = OP_NOP;
        1: op = OP_AND;
        2: op = OP_OR;
        3: op = OP_XOR;
        4: op = OP_SHIFT;
        default: op = OP_ARX;
      endcase
      issue(op, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

`ifdef MESM6_ALU_TIMEOUT_EN
    issue(OP_FADD, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    drain();
`endif

    issue(OP_ARX, 1'b0, 48'h1234_5678_9ABC, 48'h1111_1111_1111);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrun_alu_op", {44'd0, alu_op}, {44'd0, OP_NOP});
    chk("midrun_cmd_ready", {47'd0, cmd_ready}, 48'd0);
    chk("midrun_rsp_valid", {47'd0, rsp_valid}, 48'd0);
    chk("midrun_alu_a", alu_a, 48'd0);
    chk("midrun_alu_b", alu_b, 48'd0);
    chk("midrun_rsp_result", rsp_result, 48'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    issue(OP_XOR, 1'b0, 48'hAAAA_AAAA_AAAA, 48'h5555_0000_5555);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesm6_alu_ctl.md
# mesm6_alu_ctl

ALU sequencer between the instruction decoder and `mesm6_alu`. It accepts one ALU command at a time over a valid/ready handshake and drives the ALU's `op`/`a`/`b`/`wy` inputs. It waits for `done`, then captures `result`/`y` into a response register. It also enforces the mandatory `ALU_NOP` gap that clears the ALU's `done`/`count` between operations, so the decoder never sees multicycle ALU behaviour.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum RUN cycles before abort. Only used with `MESM6_ALU_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when both valid and ready are high
- `cmd_op`  in  `ALU_OP_WIDTH`  ALU operation code
- `cmd_wy`  in  1  Y := A request; meaningful only with `ALU_NOP`
- `cmd_a`, `cmd_b`  in  48  operands
- `rsp_valid`  out  1  response held
- `rsp_ready`  in  1  response consumed when both valid and ready are high
- `rsp_result`, `rsp_y`  out  48  captured ALU result / Y
- `rsp_err`  out  1  operation aborted by timeout
- `alu_op`  out  `ALU_OP_WIDTH`  to ALU `op`
- `alu_wy`  out  1  to ALU `wy`
- `alu_a`, `alu_b`  out  48  to ALU `a`, `b`
- `alu_result`, `alu_y`  in  48  from ALU
- `alu_done`  in  1  from ALU

## Operation
States and their outputs:
- INIT: entered on reset; lasts 1 cycle. `alu_op` = NOP, which clears the ALU's unreset `done`. Next state IDLE.
- IDLE: `cmd_ready` = 1, `alu_op` = NOP, `alu_a` = `cmd_a`.
  - Accepted op ≠ NOP: latch op, a and b; go to RUN.
  - Accepted op = NOP: `alu_wy` = `cmd_wy` in that same cycle; no response is generated; stay in IDLE.
- RUN: `alu_op`/`alu_a`/`alu_b` = latched values; `cmd_ready` = 0.
  - On `alu_done`: capture `alu_result`/`alu_y` and set `rsp_err` = 0; go to RESP.
- RESP: `alu_op` = NOP; `rsp_valid` = 1; response registers held stable.
  - On `rsp_ready`: go to IDLE.

Rules:
- `alu_wy` = 0 in every state other than the IDLE NOP-accept cycle.
- `alu_done` is ignored outside RUN.
- The first RUN cycle always sees `alu_done` = 0, guaranteed by the preceding NOP cycle.

## Timing
- Reset values: state INIT; `cmd_ready` 0; `rsp_valid` 0; `rsp_err` 0; `rsp_result`/`rsp_y` 0; `alu_op` `ALU_NOP`; `alu_wy` 0; `alu_a`/`alu_b` 0; latched operands 0.
- Acceptance in cycle 0 → RUN in cycle 1 → `rsp_valid` in cycle N+2, where N is the ALU cycle count (1 for AND/OR/XOR/shift/pack/unpack, 2 for ARX/ACX/ANX).
- Minimum command-to-command spacing is N+3 cycles, with `rsp_ready` held high.
- Back-to-back NOP/wy commands sustain one per cycle.
- `cmd_ready` and `rsp_valid` are never high together.
- `reset_n` assertion mid-RUN or mid-RESP: immediate return to INIT. The response is discarded and `alu_op` becomes NOP asynchronously.
- `rsp_ready` asserted while not in RESP: ignored.

## Configuration
- `MESM6_ALU_TIMEOUT_EN` defined:
  - A 4-bit RUN-cycle counter clears on RUN entry.
  - If the counter reaches `TIMEOUT` without `alu_done`, go to RESP with `rsp_err` = 1 and `rsp_result` = `rsp_y` = 0.
  - If `alu_done` arrives in the same cycle as the limit, `done` wins.
  - This covers ALU op codes that never assert `done` (e.g. `ALU_FADD`).
- `MESM6_ALU_TIMEOUT_EN` undefined: RUN waits indefinitely; `rsp_err` is tied to 0; no counter logic.

## Structure
- The `ALU_OP_WIDTH` and `ALU_*` op codes come from the shared defines (`mesm6_defines.sv`).
- The controller state enum (INIT/IDLE/RUN/RESP) and the default `TIMEOUT` belong in the shared package.
- One optional sub-module, `mesm6_alu_wdog`, holds the timeout counter. It is instantiated only under `MESM6_ALU_TIMEOUT_EN`.
- `mesm6_alu` is instantiated by the parent, not inside this block.

## Test plan
- After reset: `alu_op` = NOP for cycle 0; `cmd_ready` rises in cycle 1.
- `ALU_AND`, a=48'hF0F0_F0F0_F0F0, b=48'hFF00_FF00_FF00 → `rsp_valid` at cycle 3; `rsp_result` = 48'hF000_F000_F000; `rsp_y` = 0.
- `ALU_ADD_CARRY_AROUND`, a=48'hFFFF_FFFF_FFFF, b=1 → `rsp_valid` at cycle 4; `rsp_result` = 1.
- `ALU_SHIFT`, a=1, b[47]=0, b[46:41]=63 → `rsp_result` = 2. Hold `rsp_ready` = 0 for 5 cycles: the response stays stable, `cmd_ready` stays 0 and `alu_op` stays NOP.
- `ALU_NOP` with wy=1, a=48'h123 → `alu_wy` = 1 for one cycle; `rsp_valid` never rises; the next command is accepted in the following cycle.
- Timeout path (macro on, `TIMEOUT`=15): `ALU_FADD` → `rsp_err` = 1 after 15 RUN cycles, result 0. Separately, `reset_n` low mid-RUN → all outputs return to their reset values within the same cycle.
